// File: rtl/rx_buf_pkg.sv
// Shared types and helpers for the receive packet buffer: FSM states,
// default widths and the checksum fold.
package rx_buf_pkg;

    localparam int unsigned N_PKT_DEF    = 16;
    localparam int unsigned CHK_W_DEF    = 4;
    localparam int unsigned PAYLOAD_W    = N_PKT_DEF - CHK_W_DEF;
    localparam int unsigned FOLD_MAX_W   = 64;
    localparam int unsigned FOLD_MAX_CHK = 16;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        SETTLE
    } rx_state_t;

    // XOR of all chk_w-bit chunks of the low pay_w bits; bit i lands in lane i mod chk_w.
    function automatic logic [FOLD_MAX_CHK-1:0] xor_fold(
        input logic [FOLD_MAX_W-1:0] payload,
        input int unsigned           pay_w,
        input int unsigned           chk_w
    );
        logic [FOLD_MAX_CHK-1:0] acc;
        logic [3:0]              lane;
        acc = '0;
        for (int unsigned i = 0; i < FOLD_MAX_W; i++) begin
            if (i < pay_w) begin
                lane       = 4'(i % chk_w);
                acc[lane]  = acc[lane] ^ payload[6'(i)];
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with wrapping pointers and a separate occupancy count.
module sync_fifo
    import rx_buf_pkg::*;
#(
    parameter int unsigned WIDTH = PAYLOAD_W,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (do_push && !rst) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/rx_packet_buffer.sv
// Pulls packets from the decoder, verifies the XOR-fold checksum and queues good
// payloads for the host; bad and overflowing packets are counted and dropped.
module rx_packet_buffer
    import rx_buf_pkg::*;
#(
    parameter int unsigned N_PKT = N_PKT_DEF,
    parameter int unsigned CHK_W = CHK_W_DEF,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_PKT-1:0]           dec_data,
    input  logic                       dec_avail,
    output logic                       dec_read,
    output logic [N_PKT-CHK_W-1:0]     out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic [CNT_W-1:0]           chk_err_cnt,
    output logic [CNT_W-1:0]           ovf_cnt
);

    localparam int unsigned PAY_W = N_PKT - CHK_W;

    rx_state_t        state_q, state_d;
    logic [N_PKT-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] chk_err_q, chk_err_d;
    logic [CNT_W-1:0] ovf_q, ovf_d;
    logic [CHK_W-1:0] fold;
    logic             good, push, pop, full, empty, chk_inc, ovf_inc;

    assign fold      = CHK_W'(xor_fold(FOLD_MAX_W'(hold_q[N_PKT-1:CHK_W]), PAY_W, CHK_W));
    assign good      = (fold == hold_q[CHK_W-1:0]);
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        dec_read = 1'b0;
        push     = 1'b0;
        chk_inc  = 1'b0;
        ovf_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                if (dec_avail) begin
                    hold_d   = dec_data;
                    dec_read = 1'b1;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                state_d = SETTLE;
                if (!good)              chk_inc = 1'b1;
                else if (!full || pop)  push    = 1'b1;
                else                    ovf_inc = 1'b1;
            end
            SETTLE: begin
                // Wait out a still-high avail so one packet is never read twice.
                if (!dec_avail) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        chk_err_d = chk_err_q;
        ovf_d     = ovf_q;
        if (chk_inc && chk_err_q != {CNT_W{1'b1}}) chk_err_d = chk_err_q + CNT_W'(1);
        if (ovf_inc && ovf_q != {CNT_W{1'b1}})     ovf_d     = ovf_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            chk_err_q <= '0;
            ovf_q     <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            chk_err_q <= chk_err_d;
            ovf_q     <= ovf_d;
        end
    end

    assign chk_err_cnt = chk_err_q;
    assign ovf_cnt     = ovf_q;

    sync_fifo #(
        .WIDTH (PAY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (hold_q[N_PKT-1:CHK_W]),
        .dout  (out_data),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_rx_packet_buffer.sv
// Randomised and directed bench for rx_packet_buffer with a queue-based scoreboard.
module tb_rx_packet_buffer;

    localparam int N_PKT = 16;
    localparam int CHK_W = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int PAY_W = N_PKT - CHK_W;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [N_PKT-1:0] dec_data;
    logic             dec_avail;
    logic             dec_read;
    logic [PAY_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       fifo_count;
    logic [CNT_W-1:0] chk_err_cnt;
    logic [CNT_W-1:0] ovf_cnt;

    int total = 0;
    int bad   = 0;
    logic [PAY_W-1:0] exp_q[$];
    int exp_chk   = 0;
    int exp_ovf   = 0;
    int exp_reads = 0;
    int rd_pulses = 0;
    bit mon_en    = 0;
    bit rand_rdy  = 0;
    int rdy_pct   = 50;

    rx_packet_buffer #(
        .N_PKT (N_PKT),
        .CHK_W (CHK_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .dec_data    (dec_data),
        .dec_avail   (dec_avail),
        .dec_read    (dec_read),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .fifo_count  (fifo_count),
        .chk_err_cnt (chk_err_cnt),
        .ovf_cnt     (ovf_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] fold(input logic [11:0] p);
        int v;
        v = int'(p);
        return 4'(((v >> 8) ^ (v >> 4) ^ v) & 15);
    endfunction

    function automatic logic [15:0] mk_good(input logic [11:0] p);
        return {p, fold(p)};
    endfunction

    function automatic int sat(input int x);
        return (x < CMAX) ? x + 1 : CMAX;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares occupancy every cycle and pops the scoreboard on each accepted head.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("out_valid", int'(out_valid), int'(exp_q.size() != 0));
            chk("fifo_count", int'(fifo_count), exp_q.size());
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_pop", 1, 0);
                else chk("out_data", int'(out_data), int'(exp_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && dec_read) rd_pulses++;
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 99) < rdy_pct);
    end

    // One decoder transaction, started from the IDLE cycle; avail stays high for hold cycles.
    task automatic send(input logic [15:0] d, input int hold, input bit rdy_pulse);
        bit acc, good;
        dec_data  = d;
        dec_avail = 1'b1;
        exp_reads++;
        #1;
        chk("dec_read_idle", int'(dec_read), 1);
        tick;
        if (hold <= 1) dec_avail = 1'b0;
        if (rdy_pulse) out_ready = 1'b1;
        #1;
        chk("dec_read_check", int'(dec_read), 0);
        good = (d[3:0] == fold(d[15:4]));
        acc  = good && (exp_q.size() < DEPTH || (out_ready && exp_q.size() > 0));
        tick;
        if (rdy_pulse) out_ready = 1'b0;
        if (acc)       exp_q.push_back(d[15:4]);
        else if (good) exp_ovf = sat(exp_ovf);
        else           exp_chk = sat(exp_chk);
        chk("chk_err_cnt", int'(chk_err_cnt), exp_chk);
        chk("ovf_cnt", int'(ovf_cnt), exp_ovf);
        for (int c = 3; c <= hold + 1; c++) begin
            if (c > 3) tick;
            dec_avail = (c <= hold);
            #1;
            chk("dec_read_settle", int'(dec_read), 0);
        end
        tick;
    endtask

    task automatic drain;
        rand_rdy = 1;
        rdy_pct  = 100;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick;
        chk("drain_empty", exp_q.size(), 0);
        tick;
        rand_rdy  = 0;
        out_ready = 1'b0;
        tick;
    endtask

    initial begin
        int p0;
        logic [11:0] p;
        logic [3:0]  k;
        rst = 1'b1; dec_data = '0; dec_avail = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_fifo_count", int'(fifo_count), 0);
        chk("rst_chk_err", int'(chk_err_cnt), 0);
        chk("rst_ovf", int'(ovf_cnt), 0);
        chk("rst_dec_read", int'(dec_read), 0);
        mon_en = 1;

        // Single good packet, then a bad checksum.
        send(16'hABCD, 1, 0);
        chk("good_head", int'(out_data), 12'hABC);
        drain();
        send(16'hABC0, 1, 0);
        chk("bad_fifo_count", int'(fifo_count), 0);

        // Overflow with the consumer stalled.
        for (int i = 1; i <= 5; i++) send(mk_good(12'(12'h111 * i)), 1, 0);
        chk("ovf_after_five", int'(ovf_cnt), 1);
        drain();

        // Push and pop in the same cycle while full.
        for (int i = 7; i <= 10; i++) send(mk_good(12'(12'h111 * i)), 1, 0);
        send(mk_good(12'h666), 1, 1);
        chk("full_pushpop_count", int'(fifo_count), 4);
        drain();

        // Avail stuck high: exactly one read.
        p0 = rd_pulses;
        send(mk_good(12'h5A5), 6, 0);
        chk("sticky_one_read", rd_pulses - p0, 1);
        drain();

        // Reset while a good packet sits in CHECK.
        send(mk_good(12'h321), 1, 0);
        send(16'hFFF0, 1, 0);
        dec_data = mk_good(12'h123); dec_avail = 1'b1; exp_reads++;
        tick;
        dec_avail = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        exp_q.delete(); exp_chk = 0; exp_ovf = 0;
        chk("rstchk_out_valid", int'(out_valid), 0);
        chk("rstchk_fifo_count", int'(fifo_count), 0);
        chk("rstchk_chk_err", int'(chk_err_cnt), 0);
        chk("rstchk_ovf", int'(ovf_cnt), 0);
        chk("rstchk_dec_read", int'(dec_read), 0);
        tick;

        // Bad-checksum counter saturation.
        for (int i = 0; i < CMAX + 5; i++) begin
            p = 12'($urandom);
            k = 4'($urandom_range(1, 15));
            send({p, fold(p) ^ k}, 1, 0);
        end
        chk("chk_err_saturated", int'(chk_err_cnt), CMAX);

        // Random traffic against the model.
        rand_rdy = 1;
        rdy_pct  = 40;
        for (int i = 0; i < 80; i++) begin
            p = 12'($urandom);
            if ($urandom_range(0, 99) < 70) send(mk_good(p), int'($urandom_range(1, 3)), 0);
            else send({p, fold(p) ^ 4'($urandom_range(1, 15))}, int'($urandom_range(1, 3)), 0);
            repeat ($urandom_range(0, 2)) tick;
        end
        drain();
        chk("total_reads", rd_pulses, exp_reads);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rx_packet_buffer.md
Name: rx_packet_buffer

Overview:
Downstream consumer of the OPPM decoder. Pulls each decoded packet through the decoder's avail/read handshake and verifies a trailing XOR-fold checksum. Good payloads go into a small FIFO; bad or overflowing packets are dropped and counted. Presents a valid/ready stream to the host-side logic.

Parameters:
N_PKT, 16, decoded packet width in bits (matches decoder N_PKT)
CHK_W, 4, checksum width in bits, held in packet LSBs; (N_PKT-CHK_W) % CHK_W == 0 required
DEPTH, 4, FIFO depth in payloads; power of two, >= 2
CNT_W, 8, width of saturating error/drop counters

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is synchronous and active-high
dec_data  in  N_PKT  decoded packet from decoder, payload MSBs then checksum
dec_avail  in  1  decoder has a packet ready
dec_read  out  1  single-cycle acknowledge to decoder
out_data  out  N_PKT-CHK_W  FIFO head payload
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts head this cycle
fifo_count  out  $clog2(DEPTH+1)  current occupancy
chk_err_cnt  out  CNT_W  packets dropped for bad checksum, saturating
ovf_cnt  out  CNT_W  good packets dropped because FIFO full, saturating

Behaviour:
- Reset, sync on rst=1 at posedge: state=IDLE, dec_read=0, out_valid=0, fifo_count=0, both counters=0, hold register=0, FIFO pointers=0. FIFO storage is not cleared. rst mid-packet discards the hold register; the decoder is not re-acknowledged.
- Checksum: split payload P = dec_data[N_PKT-1:CHK_W] into CHK_W-bit chunks. Expected = XOR of all chunks. Good iff expected == dec_data[CHK_W-1:0].
- FSM states: IDLE, CHECK, SETTLE.
- IDLE: if dec_avail=1, latch dec_data into the hold register, drive dec_read=1 (combinational, this cycle only), go to CHECK. Else stay.
- CHECK, exactly one cycle, dec_read=0:
  - If hold is good and push is allowed, push the payload.
  - If hold is good and push is not allowed, ovf_cnt++.
  - If hold is bad, chk_err_cnt++.
  - Next state: SETTLE.
- SETTLE: wait for dec_avail=0, then go to IDLE. This guarantees no double-read of one packet.
  - Decoder avail is registered, so it normally reads 0 here and SETTLE lasts 1 cycle.
  - If dec_avail stays high, remain in SETTLE with dec_read=0.
- Packet latency: dec_avail high to out_valid high is 2 cycles, when the FIFO was empty (IDLE cycle, CHECK cycle, visible next).
- Max acceptance rate is one packet per 3 cycles.
- FIFO: show-ahead, out_data = head whenever out_valid=1.
  - Pop occurs when out_valid & out_ready. out_ready while empty is ignored.
  - Push allowed iff fifo_count<DEPTH, or a pop occurs the same cycle.
  - Simultaneous push and pop at full: both happen, count unchanged.
  - Simultaneous push and pop at empty: push only, since out_valid=0.
  - Pointers are $clog2(DEPTH) bits and wrap naturally. fifo_count is tracked separately: +1 on push only, -1 on pop only.
- Counters saturate at 2^CNT_W-1 and never wrap. Both counters cannot increment in the same cycle.
- out_data/out_valid/fifo_count come from registers or FIFO memory read; no combinational path from dec_* to out_*.

Decomposition:
- Package rx_buf_pkg:
  - PAYLOAD_W localparam convention (N_PKT-CHK_W).
  - rx_state_t enum {IDLE, CHECK, SETTLE}.
  - Function xor_fold(payload) returning CHK_W bits, parameterised via widths passed from the module.
- Sub-module sync_fifo #(WIDTH, DEPTH): push, pop, din, dout, count, full, empty; synchronous active-high rst.
- rx_packet_buffer instantiates sync_fifo and holds the FSM, hold register, checker and counters.

Test Plan:
- Good packet: N_PKT=16, CHK_W=4, dec_data=16'hABCD (A^B^C=D), dec_avail pulse following decoder avail/read timing, out_ready=0 -> dec_read high exactly 1 cycle; 2 cycles later out_valid=1, out_data=12'hABC, fifo_count=1, counters 0.
- Bad checksum: dec_data=16'hABC0 -> dec_read pulses once, FIFO unchanged, chk_err_cnt=1, out_valid stays 0.
- Overflow: out_ready=0, send 5 good packets (12'h111..12'h555, each with matching checksum) -> fifo_count=4, ovf_cnt=1; drain with out_ready=1 yields 111,222,333,444 in order, then out_valid=0.
- Push/pop at full: FIFO full with 4 entries, out_ready=1 held during the CHECK cycle of good packet 12'h666 -> packet accepted, ovf_cnt unchanged, fifo_count stays 4, last entry read out is 12'h666.
- Sticky avail: hold dec_avail=1 for 6 cycles with one packet -> exactly one dec_read pulse; FSM stays in SETTLE until dec_avail=0.
- Reset and saturation: assert rst in CHECK -> next cycle all outputs 0, no push. With CNT_W=2, send 5 bad packets -> chk_err_cnt=3.
